// File: rtl/coin_wait_timer_if.sv
// Signal bundle between the input-decode logic, the coin wait timer and the change/return controller.
// The master drives the activity/control strobes; the slave (the timer) drives the status outputs.
interface coin_wait_timer_if #(
  parameter int NUM_COINS = 3,
  parameter int NUM_ITEMS = 4,
  parameter int TIME_W    = 32
);
  logic [NUM_COINS-1:0] i_input_coin;
  logic [NUM_ITEMS-1:0] i_select_item;
  logic                 i_hold;
  logic                 i_clear;
  logic [TIME_W-1:0]    wait_time;
  logic                 o_active;
  logic                 o_timeout;
  logic                 o_expired;

  modport master (
    output i_input_coin, i_select_item, i_hold, i_clear,
    input  wait_time, o_active, o_timeout, o_expired
  );

  modport slave (
    input  i_input_coin, i_select_item, i_hold, i_clear,
    output wait_time, o_active, o_timeout, o_expired
  );
endinterface

// File: rtl/coin_wait_timer.sv
// Coin-return wait timer: reloads on any coin/item activity, counts down once per clock,
// and reports expiry as a one-cycle pulse plus a sticky flag until acknowledged.
module coin_wait_timer #(
  parameter int              NUM_COINS = 3,
  parameter int              NUM_ITEMS = 4,
  parameter int              TIME_W    = 32,
  parameter longint unsigned WAIT_TIME = 100
) (
  input logic              clk,
  input logic              reset_n,
  coin_wait_timer_if.slave bus
);
  localparam logic [TIME_W-1:0] RELOAD = TIME_W'(WAIT_TIME);
  localparam logic [TIME_W-1:0] ONE    = TIME_W'(1);
  localparam logic [TIME_W-1:0] ZERO   = TIME_W'(0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    EXPIRED  = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [TIME_W-1:0]    wait_time_r, wait_time_nxt_s;
  logic                 active_r, timeout_r, expired_r;
  logic                 timeout_nxt_s, expired_nxt_s;
  logic [NUM_COINS-1:0] coin_s;
  logic [NUM_ITEMS-1:0] item_s;
  logic                 act_s;

  assign coin_s = bus.i_input_coin;
  assign item_s = bus.i_select_item;
  assign act_s  = (|coin_s) | (|item_s);

  // Next-state and next-output logic; activity outranks clear, clear outranks hold.
  always_comb begin
    state_nxt_s     = state_r;
    wait_time_nxt_s = wait_time_r;
    timeout_nxt_s   = 1'b0;
    expired_nxt_s   = expired_r;
    if (act_s) begin
      state_nxt_s     = COUNTING;
      wait_time_nxt_s = RELOAD;
      expired_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wait_time_nxt_s = RELOAD;
          expired_nxt_s   = 1'b0;
        end
        COUNTING: begin
          if (bus.i_hold) begin
            wait_time_nxt_s = wait_time_r;
          end else if (wait_time_r <= ONE) begin
            // Also catches a zero count so the counter can never wrap.
            wait_time_nxt_s = ZERO;
            state_nxt_s     = EXPIRED;
            timeout_nxt_s   = 1'b1;
            expired_nxt_s   = 1'b1;
          end else begin
            wait_time_nxt_s = wait_time_r - ONE;
          end
        end
        EXPIRED: begin
          if (bus.i_clear) begin
            state_nxt_s     = IDLE;
            wait_time_nxt_s = RELOAD;
            expired_nxt_s   = 1'b0;
          end else begin
            wait_time_nxt_s = ZERO;
            expired_nxt_s   = 1'b1;
          end
        end
        default: begin
          state_nxt_s     = IDLE;
          wait_time_nxt_s = RELOAD;
          expired_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      wait_time_r <= RELOAD;
      active_r    <= 1'b0;
      timeout_r   <= 1'b0;
      expired_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wait_time_r <= wait_time_nxt_s;
      active_r    <= (state_nxt_s == COUNTING);
      timeout_r   <= timeout_nxt_s;
      expired_r   <= expired_nxt_s;
    end
  end

  assign bus.wait_time = wait_time_r;
  assign bus.o_active  = active_r;
  assign bus.o_timeout = timeout_r;
  assign bus.o_expired = expired_r;
endmodule
